// File: rtl/mac_job_sched_if.sv
// Job/response and MAC-datapath bundle shared by the scheduler and its clients.
// No logic here; timing is set entirely by mac_job_sched.
// master = client engines plus the MAC unit, slave = scheduler.
interface mac_job_sched_if #(
  parameter int N_REQ = 2,
  parameter int W     = 256
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic [N_REQ-1:0]   resp_valid;
  logic [N_REQ-1:0]   resp_ready;
  logic [2*W-1:0]     resp_data;
  logic [W-1:0]       mac_a;
  logic [W-1:0]       mac_b;
  logic               mac_en;
  logic               mac_rst_n;
  logic [2*W-1:0]     mac_out;

  modport master (
    output req_valid, req_a, req_b, resp_ready, mac_out,
    input  req_ready, resp_valid, resp_data, mac_a, mac_b, mac_en, mac_rst_n
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready, mac_out,
    output req_ready, resp_valid, resp_data, mac_a, mac_b, mac_en, mac_rst_n
  );
endinterface

// File: rtl/mac_job_sched.sv
// Round-robin scheduler sharing one 256x256 radix-4 MAC between N_REQ clients.
// Latency: resp_valid rises MAC_LAT+2 edges after the request handshake edge.
// Backpressure: one job in flight; req_ready only in IDLE, DONE holds until resp_ready[grant].
module mac_job_sched #(
  parameter int N_REQ   = 2,
  parameter int W       = 256,
  parameter int MAC_LAT = 130
) (
  input  logic              clk,
  input  logic              rst,
  mac_job_sched_if.slave    bus,
  output logic              busy
);

  localparam int CW = $clog2(MAC_LAT + 1);
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [GW-1:0]  last_grant_q, last_grant_d;
  logic [GW-1:0]  grant_q, grant_d;
  logic [W-1:0]   mac_a_q, mac_a_d;
  logic [W-1:0]   mac_b_q, mac_b_d;
  logic [2*W-1:0] resp_data_q, resp_data_d;

  logic           win_vld;
  logic [GW-1:0]  win_id;
  logic [GW-1:0]  cand;
  logic           in_idle;

  // Round-robin search starting just after the last granted requester.
  // Walking k downwards lets the nearest valid candidate overwrite farther ones.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    cand    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = GW'((int'(last_grant_q) + k) % N_REQ);
      if (bus.req_valid[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  // Reset is gated into the outputs so nothing is offered or enabled while rst is high.
  assign in_idle        = (state_q == S_IDLE) && !rst;
  assign bus.req_ready  = (in_idle && win_vld) ? (N_REQ'(1) << win_id) : '0;
  assign bus.resp_valid = ((state_q == S_DONE) && !rst) ? (N_REQ'(1) << grant_q) : '0;
  assign bus.resp_data  = resp_data_q;
  assign bus.mac_a      = mac_a_q;
  assign bus.mac_b      = mac_b_q;
  assign bus.mac_en     = (state_q == S_RUN) && !rst;
  assign bus.mac_rst_n  = !rst && (state_q != S_CLEAR);
  assign busy           = (state_q != S_IDLE);

  // Job sequencing: accept, clear MAC, run MAC_LAT enabled cycles, capture, return.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    mac_a_d      = mac_a_q;
    mac_b_d      = mac_b_q;
    resp_data_d  = resp_data_q;
    case (state_q)
      S_IDLE: begin
        // Operands are sampled only here; later changes on req_a/req_b are ignored.
        if (win_vld) begin
          mac_a_d      = bus.req_a[int'(win_id)*W +: W];
          mac_b_d      = bus.req_b[int'(win_id)*W +: W];
          grant_d      = win_id;
          last_grant_d = win_id;
          state_d      = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(MAC_LAT - 1)) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        // mac_en is already low, so mac_out is stable when sampled here.
        resp_data_d = bus.mac_out;
        state_d     = S_DONE;
      end
      S_DONE: begin
        // Only the granted requester's ready releases the result.
        if (bus.resp_ready[grant_q]) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset leaves requester 0 with top priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_grant_q <= GW'(N_REQ - 1);
      grant_q      <= '0;
      mac_a_q      <= '0;
      mac_b_q      <= '0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      mac_a_q      <= mac_a_d;
      mac_b_q      <= mac_b_d;
      resp_data_q  <= resp_data_d;
    end
  end

endmodule

// File: tb/tb_mac_job_sched.sv
// Directed bench for mac_job_sched with a behavioural MAC.
// Checks reset state, latency, arbitration order, hold-under-backpressure, reset abort.
// Inputs are driven and outputs sampled on the falling edge.
module tb_mac_job_sched;

  localparam int N_REQ   = 2;
  localparam int W       = 256;
  localparam int MAC_LAT = 130;
  localparam int LAT     = MAC_LAT + 2;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  always #5 clk = ~clk;

  mac_job_sched_if #(.N_REQ(N_REQ), .W(W)) bus ();

  mac_job_sched #(.N_REQ(N_REQ), .W(W), .MAC_LAT(MAC_LAT)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  // Behavioural MAC: the product appears only after exactly MAC_LAT enabled
  // cycles with unchanged operands since the last clear.
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  int           m_cnt = 0;
  logic         m_bad = 1'b0;

  always @(posedge clk) begin
    if (!bus.mac_rst_n) begin
      m_cnt <= 0;
      m_bad <= 1'b0;
    end else if (bus.mac_en) begin
      if (m_cnt == 0) begin
        m_a <= bus.mac_a;
        m_b <= bus.mac_b;
      end else if (bus.mac_a != m_a || bus.mac_b != m_b) begin
        m_bad <= 1'b1;
      end
      m_cnt <= m_cnt + 1;
    end
  end

  assign bus.mac_out = (m_cnt == MAC_LAT && !m_bad)
                     ? ({{W{1'b0}}, m_a} * {{W{1'b0}}, m_b})
                     : (512'(m_cnt) + 512'hBAD0);

  // Edge counter and handshake recorder.
  int edge_n  = 0;
  int hs_edge = 0;
  int hs_id   = -1;
  logic multi_hot = 1'b0;

  always @(posedge clk) begin
    edge_n++;
    if (|(bus.req_valid & bus.req_ready)) begin
      hs_edge = edge_n;
      for (int i = 0; i < N_REQ; i++)
        if (bus.req_ready[i]) hs_id = i;
    end
  end

  always @(negedge clk) begin
    if ($countones(bus.req_ready) > 1 || $countones(bus.resp_valid) > 1)
      multi_hot = 1'b1;
  end

  int n_chk  = 0;
  int n_fail = 0;
  logic busy_lo;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_a[idx*W +: W] = a;
    bus.req_b[idx*W +: W] = b;
  endtask

  // Called on a falling edge; returns on the falling edge where a response is visible.
  task automatic wait_resp(input string tag, output int lat);
    int t;
    t   = 0;
    lat = -1;
    while (bus.resp_valid == '0 && t < 400) begin
      if (!busy) busy_lo = 1'b1;
      @(negedge clk);
      t++;
    end
    if (bus.resp_valid != '0) lat = edge_n - hs_edge;
    else chk({tag, "_timeout"}, 1, 0);
  endtask

  task automatic ack_cur();
    bus.resp_ready = bus.resp_valid;
    @(negedge clk);
    bus.resp_ready = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  int lat;
  logic unstable, rd1_seen, vld_seen;
  logic [511:0] big_exp;

  initial begin
    rst            = 1'b1;
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = '0;

    // Reset state, with a pending request that must not be offered.
    repeat (2) @(negedge clk);
    bus.req_valid = 2'b01;
    #1;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_mac_en", bus.mac_en, 0);
    chk("rst_mac_rst_n", bus.mac_rst_n, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mac_a", bus.mac_a, 0);
    chk("rst_resp_data", bus.resp_data, 0);
    bus.req_valid = '0;
    rst = 1'b0;
    @(negedge clk);

    // Single job 32*32.
    set_op(0, 32, 32);
    bus.req_valid = 2'b01;
    #1 chk("t1_ready", bus.req_ready, 2'b01);
    @(negedge clk);
    bus.req_valid = '0;
    busy_lo = 1'b0;
    wait_resp("t1", lat);
    chk("t1_lat", lat, LAT);
    chk("t1_vld", bus.resp_valid, 2'b01);
    chk("t1_data", bus.resp_data, 1024);
    chk("t1_busy", busy_lo, 0);
    ack_cur();
    chk("t1_idle", busy, 0);

    // Simultaneous requests from a fresh reset: requester 0 first.
    do_reset();
    set_op(0, 5, 10);
    set_op(1, 100, 100);
    bus.req_valid = 2'b11;
    #1 chk("t2_ready0", bus.req_ready, 2'b01);
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    chk("t2_gnt0", hs_id, 0);
    wait_resp("t2a", lat);
    chk("t2_data0", bus.resp_data, 50);
    ack_cur();
    chk("t2_ready1", bus.req_ready, 2'b10);
    @(negedge clk);
    bus.req_valid = '0;
    chk("t2_gnt1", hs_id, 1);
    wait_resp("t2b", lat);
    chk("t2_lat1", lat, LAT);
    chk("t2_data1", bus.resp_data, 10000);
    ack_cur();

    // Continuous contention: grants alternate 0,1,0,1.
    set_op(0, 3, 7);
    set_op(1, 11, 13);
    bus.req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_resp("t3", lat);
      chk("t3_gnt", hs_id, i % 2);
      chk("t3_vld", bus.resp_valid, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("t3_data", bus.resp_data, (i % 2 == 0) ? 21 : 143);
      if (i == 3) bus.req_valid = '0;
      ack_cur();
    end

    // Backpressure on requester 0 while requester 1 waits.
    set_op(0, 6, 7);
    bus.req_valid = 2'b01;
    @(negedge clk);
    bus.req_valid = 2'b10;
    set_op(1, 2, 9);
    wait_resp("t4a", lat);
    chk("t4_vld", bus.resp_valid, 2'b01);
    chk("t4_data", bus.resp_data, 42);
    bus.resp_ready = 2'b10;
    unstable = 1'b0;
    rd1_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.resp_valid != 2'b01 || bus.resp_data != 512'd42) unstable = 1'b1;
      if (bus.req_ready[1]) rd1_seen = 1'b1;
    end
    chk("t4_stable", unstable, 0);
    chk("t4_rdy1_low", rd1_seen, 0);
    bus.resp_ready = 2'b01;
    @(negedge clk);
    bus.resp_ready = '0;
    chk("t4_idle", busy, 0);
    chk("t4_ready1", bus.req_ready, 2'b10);
    @(negedge clk);
    bus.req_valid = '0;
    wait_resp("t4b", lat);
    chk("t4_data1", bus.resp_data, 18);
    ack_cur();

    // Reset while RUN has cnt=50.
    set_op(0, 9, 9);
    bus.req_valid = 2'b01;
    @(negedge clk);
    bus.req_valid = '0;
    while (edge_n < hs_edge + 51) @(negedge clk);
    chk("t5_run_en", bus.mac_en, 1);
    rst = 1'b1;
    #1;
    chk("t5_en_drop", bus.mac_en, 0);
    chk("t5_mrst", bus.mac_rst_n, 0);
    @(negedge clk);
    chk("t5_busy", busy, 0);
    chk("t5_en", bus.mac_en, 0);
    chk("t5_mrst2", bus.mac_rst_n, 0);
    rst = 1'b0;
    vld_seen = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (bus.resp_valid != '0 || bus.mac_en) vld_seen = 1'b1;
    end
    chk("t5_no_resp", vld_seen, 0);
    set_op(0, 12, 12);
    bus.req_valid = 2'b01;
    @(negedge clk);
    bus.req_valid = '0;
    wait_resp("t5", lat);
    chk("t5_lat", lat, LAT);
    chk("t5_data", bus.resp_data, 144);
    ack_cur();

    // Full-width operands; operands changed after acceptance.
    set_op(0, {W{1'b1}}, {W{1'b1}});
    bus.req_valid = 2'b01;
    @(negedge clk);
    bus.req_valid = '0;
    repeat (40) @(negedge clk);
    set_op(0, 0, 5);
    @(negedge clk);
    chk("t6_mac_a_held", bus.mac_a, {W{1'b1}});
    wait_resp("t6", lat);
    big_exp = 512'd0 - (512'd1 << 257) + 512'd1;
    chk("t6_data", bus.resp_data, big_exp);
    chk("t6_lat", lat, LAT);
    ack_cur();

    chk("multi_hot", multi_hot, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
